// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
// Contents: default operand width, op encodings, FSM state enum, op decode helpers.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } state_e;

    function automatic logic op_is_div(op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic op_is_signed(op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bus between the pipeline and the multiply/divide controller.
// master: pipeline side (drives start/op/operands/moves/rd_req, observes HI/LO and status).
// slave : controller side.
interface muldiv_if #(
    parameter int unsigned WIDTH = muldiv_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;
    logic             div_by_zero;
    logic             unsupported;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, wdata, rd_req,
        input  hi, lo, busy, done, stall, div_by_zero, unsupported
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, wdata, rd_req,
        output hi, lo, busy, done, stall, div_by_zero, unsupported
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiplier / restoring divider (purely combinational).
// Ports: div    - select divide step instead of multiply step
//        acc_hi - partial product (MUL) / partial remainder (DIV)
//        acc_lo - multiplier being shifted out (MUL) / dividend shifting into quotient (DIV)
//        opnd   - multiplicand magnitude (MUL) / divisor magnitude (DIV)
//        nxt_hi, nxt_lo - accumulator after this step
// Macro MULDIV_DIV_EN: include the divide step; otherwise only the multiply step exists.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    // Shift-add: add multiplicand when the current multiplier bit is set, then shift
    // {carry, sum, multiplier} right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Restoring subtract: bring the next dividend bit into the remainder and subtract
    // the divisor if it fits. The true difference is below the divisor, so WIDTH bits suffice.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, opnd};
    assign diff    = shifted[WIDTH-1:0] - opnd;

    assign nxt_hi = div ? (fits ? diff : shifted[WIDTH-1:0]) : mul_hi;
    assign nxt_lo = div ? {acc_lo[WIDTH-2:0], fits} : mul_lo;
`else
    logic unused_div;
    assign unused_div = div;

    assign nxt_hi = mul_hi;
    assign nxt_lo = mul_lo;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequential HI/LO multiply/divide unit: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE.
// Ports: clk   - rising-edge clock
//        reset - synchronous, active-high; aborts any operation without a done pulse
//        bus   - muldiv_if.slave: start/op/rs_val/rt_val launch, mthi/mtlo/wdata moves,
//                rd_req (MFHI/MFLO), hi/lo, busy/done/stall/div_by_zero/unsupported
// Macro MULDIV_DIV_EN: enables DIV/DIVU. Without it, a divide start is ignored and
// unsupported pulses for one cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, done_q, done_d;

    op_e              op_sel;
    logic             op_signed, op_div, op_ok, launch, busy;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag, step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_sel    = op_e'(bus.op);
    assign op_signed = op_is_signed(op_sel);
    assign op_div    = op_is_div(op_sel);
    assign rs_neg    = op_signed & bus.rs_val[WIDTH-1];
    assign rt_neg    = op_signed & bus.rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
    assign launch    = (state_q == StIdle) & bus.start & op_ok;
    assign busy      = (state_q != StIdle);

    assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef MULDIV_DIV_EN
    logic             dz_q, rem_neg_q, dbz_q;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            dz_q      <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            dbz_q <= (state_q == StFix) & dz_q;
            if (launch) begin
                dz_q      <= op_div & (bus.rt_val == '0);
                rem_neg_q <= rs_neg;
            end
        end
    end

    // Divide by zero runs the normal iterations: the remainder ends up as |rs|, which the
    // dividend-sign fix turns back into rs; only the quotient needs forcing.
    assign quo_fix = dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    assign rem_fix = rem_neg_q ? -acc_hi_q : acc_hi_q;
    assign fix_hi  = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo  = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    assign op_ok   = 1'b1;

    assign bus.div_by_zero = dbz_q;
    assign bus.unsupported = 1'b0;
`else
    logic unsup_q;

    always_ff @(posedge clk) begin
        if (reset) unsup_q <= 1'b0;
        else       unsup_q <= (state_q == StIdle) & bus.start & op_div;
    end

    assign fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo = prod_fix[WIDTH-1:0];
    assign op_ok  = ~op_div;

    assign bus.div_by_zero = 1'b0;
    assign bus.unsupported = unsup_q;
`endif

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div   (is_div_q),
        .acc_hi(acc_hi_q),
        .acc_lo(acc_lo_q),
        .opnd  (opnd_q),
        .nxt_hi(step_hi),
        .nxt_lo(step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d  = StIter;
                    cnt_d    = CntLoad;
                    acc_hi_d = '0;
                    acc_lo_d = op_div ? rs_mag : rt_mag;
                    opnd_d   = op_div ? rt_mag : rs_mag;
                    is_div_d = op_div;
                    neg_d    = rs_neg ^ rt_neg;
                end else if (!bus.start) begin
                    // Any start in IDLE (even an unsupported one) drops same-cycle moves.
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            StIter: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                state_d = StIdle;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.stall = busy & (bus.rd_req | bus.start | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (WIDTH=32): directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] m_hi, m_lo, eh, el;
    logic        edz;
    int          bad;
    bit          seen;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        rdz = 1'b0;
        p   = '0;
        q   = 0;
        r   = 0;
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = ua * ub;
            2'd2: begin q = (b == 0) ? 0 : sa / sb; r = (b == 0) ? 0 : sa % sb; end
            default: begin q = (b == 0) ? 0 : ua / ub; r = (b == 0) ? 0 : ua % ub; end
        endcase
        if (op < 2'd2) begin
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 0) begin
            rh  = a;
            rl  = 32'hFFFF_FFFF;
            rdz = 1'b1;
        end else begin
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mtlo);
        logic [31:0] rh, rl;
        logic        rdz;
        int          done_cyc;
        bit          stable;
        model(op, a, b, rh, rl, rdz);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        if (with_mtlo) begin
            bus.mtlo  = 1'b1;
            bus.wdata = 32'hDEAD_BEEF;
        end
        tick();
        bus.start  = 1'b0;
        bus.mtlo   = 1'b0;
        bus.rs_val = $urandom();
        bus.rt_val = $urandom();
        done_cyc   = -1;
        stable     = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b1) stable = 1'b0;
            tick();
        end
        check_eq($sformatf("latency op%0d", op), done_cyc, 34);
        check_eq($sformatf("hold_while_busy op%0d", op), stable, 1);
        check_eq($sformatf("busy_at_done op%0d", op), bus.busy, 0);
        check_eq($sformatf("hi op%0d a=%h b=%h", op, a, b), bus.hi, rh);
        check_eq($sformatf("lo op%0d a=%h b=%h", op, a, b), bus.lo, rl);
        check_eq($sformatf("div_by_zero op%0d", op), bus.div_by_zero, rdz);
        check_eq($sformatf("unsupported op%0d", op), bus.unsupported, 0);
        m_hi = rh;
        m_lo = rl;
        tick();
        check_eq($sformatf("done_one_cycle op%0d", op), bus.done, 0);
    endtask

    initial begin
        int op_max;
        checks      = 0;
        failures    = 0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wdata   = '0;
        bus.rd_req  = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        check_eq("reset_hi", bus.hi, 0);
        check_eq("reset_lo", bus.lo, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        check_eq("reset_dbz", bus.div_by_zero, 0);
        check_eq("reset_unsup", bus.unsupported, 0);
        bus.rd_req = 1'b1;
        #1;
        check_eq("idle_stall", bus.stall, 0);
        bus.rd_req = 1'b0;
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;

        // Moves while idle
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.mthi = 1'b0;
        check_eq("mthi_hi", bus.hi, 32'h0000_1234);
        check_eq("mthi_lo_kept", bus.lo, m_lo);
        m_hi = 32'h0000_1234;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hA5A5_5A5A;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check_eq("mthi_mtlo_hi", bus.hi, 32'hA5A5_5A5A);
        check_eq("mthi_mtlo_lo", bus.lo, 32'hA5A5_5A5A);
        m_hi = 32'hA5A5_5A5A;
        m_lo = 32'hA5A5_5A5A;

        // Directed products
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        check_eq("multu_max_lo", bus.lo, 32'h0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        check_eq("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

`ifdef MULDIV_DIV_EN
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check_eq("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd5, 32'd0, 1'b0);
        check_eq("divu_zero_hi", bus.hi, 32'h0000_0005);
        check_eq("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf_lo", bus.lo, 32'h8000_0000);
        check_eq("div_ovf_hi", bus.hi, 32'h0000_0000);
        op_max = 3;
`else
        // Divide request without divider: ignored, moves dropped, one-cycle flag
        bus.start  = 1'b1;
        bus.op     = 2'd2;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd3;
        bus.mthi   = 1'b1;
        bus.wdata  = 32'h0BAD_0BAD;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check_eq("unsup_busy", bus.busy, 0);
        check_eq("unsup_flag", bus.unsupported, 1);
        check_eq("unsup_hi", bus.hi, m_hi);
        check_eq("unsup_lo", bus.lo, m_lo);
        tick();
        check_eq("unsup_pulse", bus.unsupported, 0);
        check_eq("unsup_idle", bus.busy, 0);
        op_max = 1;
`endif

        // Stall while busy; second start and move ignored
        model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, edz);
        bus.start  = 1'b1;
        bus.op     = 2'd1;
        bus.rs_val = 32'h1234_5678;
        bus.rt_val = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
        #1;
        check_eq("stall_no_req", bus.stall, 0);
        tick();
        tick();
        bus.rd_req = 1'b1;
        bus.start  = 1'b1;
        bus.op     = 2'd0;
        bus.rs_val = $urandom();
        bus.rt_val = $urandom();
        bus.mthi   = 1'b1;
        bus.wdata  = 32'hCAFE_F00D;
        bad = 0;
        for (int c = 3; c <= 33; c++) begin
            #1;
            if (bus.stall !== 1'b1) bad++;
            tick();
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        #1;
        check_eq("stall_cycles_missing", bad, 0);
        check_eq("stall_after_busy", bus.stall, 0);
        check_eq("stall_done", bus.done, 1);
        check_eq("stall_hi", bus.hi, eh);
        check_eq("stall_lo", bus.lo, el);
        m_hi = eh;
        m_lo = el;
        tick();
        bus.rd_req = 1'b0;
        check_eq("second_start_ignored", bus.busy, 0);

        // Reset in cycle 10 of a MULT
        bus.start  = 1'b1;
        bus.op     = 2'd0;
        bus.rs_val = 32'h0001_0003;
        bus.rt_val = 32'hFFFF_0005;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_hi", bus.hi, 0);
        check_eq("abort_lo", bus.lo, 0);
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            if (bus.done) seen = 1'b1;
            tick();
        end
        check_eq("abort_no_done", seen, 0);

        // Random operations
        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, op_max)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  launch multiply/divide; sampled only when busy=0.
REQ-005 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports: rs_val, rt_val  input  WIDTH  operands (multiplicand/dividend = rs_val).
REQ-007 SHALL have ports: mthi, mtlo  input  1  direct HI/LO write of wdata.
REQ-008 SHALL have port: wdata  input  WIDTH  MTHI/MTLO data.
REQ-009 SHALL have port: rd_req  input  1  MFHI/MFLO in the pipeline stage reading HI/LO.
REQ-010 SHALL have ports: hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-011 SHALL have ports: busy, done, stall, div_by_zero, unsupported  output  1 each.

Function
REQ-012 SHALL implement FSM IDLE -> ITER -> FIX -> IDLE; busy=1 in ITER and FIX only.
REQ-013 SHALL, on start=1 in IDLE (cycle 0), latch operands/op and enter ITER in cycle 1.
REQ-014 SHALL spend exactly WIDTH cycles in ITER, one shift-add (MUL) or restoring-subtract (DIV) step per cycle, driven by a down-counter that wraps WIDTH-1 -> 0 into FIX.
REQ-015 SHALL, in FIX, apply sign correction and write hi/lo at its ending edge; done=1 for exactly one cycle (cycle WIDTH+2), busy=0 in that cycle.
REQ-016 SHALL compute signed ops on magnitudes: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-017 SHALL produce mult results as full 2*WIDTH product, hi = upper half, lo = lower half.
REQ-018 SHALL, for rt_val=0 on DIV/DIVU, keep normal latency, force hi=rs_val, lo=all ones, pulse div_by_zero with done.
REQ-019 SHALL give DIV MIN/-1: lo=MIN, hi=0, no flag.
REQ-020 SHALL drive stall = busy & (rd_req | start | mthi | mtlo), combinationally.
REQ-021 SHALL ignore start, mthi, mtlo while busy=1 (no state change).
REQ-022 SHALL, in IDLE, write hi/lo from wdata on mthi/mtlo at the next edge; both may assert together.
REQ-023 SHALL give start priority over mthi/mtlo in the same IDLE cycle; the moves are dropped.
REQ-024 SHALL keep hi/lo stable during busy, changing only at the FIX edge.

Reset
REQ-025 SHALL, on reset=1 at an edge, force IDLE, hi=lo=0, counter=0, busy=done=div_by_zero=unsupported=0, aborting any operation with no done pulse.
REQ-026 SHALL give reset priority over all other inputs.

Configuration
REQ-027 SHALL gate the divider datapath with macro MULDIV_DIV_EN.
REQ-028 SHALL, when MULDIV_DIV_EN is defined, support all four ops; unsupported tied 0.
REQ-029 SHALL, when undefined, omit divider logic; start with op[1]=1 is ignored (stays IDLE, hi/lo unchanged) and unsupported pulses 1 cycle.

Structure
REQ-030 SHALL place op encodings, FSM state enum and default WIDTH in shared package muldiv_pkg.
REQ-031 SHALL implement the per-cycle add/subtract step in sub-module muldiv_step; FSM, counter, sign fix and HI/LO in muldiv_ctrl.

Verification (WIDTH=32)
REQ-032 SHALL test MULTU 0xFFFFFFFF*0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL test MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL test DIVU 5/0 -> hi=0x00000005, lo=0xFFFFFFFF, div_by_zero=1 with done; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL test rd_req and second start held from cycle 3 -> stall=1 cycles 3..33, second start ignored, stall=0 in cycle 34.
REQ-036 SHALL test reset in cycle 10 of a MULT -> busy=0, hi=lo=0 in cycle 11, no done pulse.
REQ-037 SHALL test idle mthi, wdata=0x00001234 -> hi=0x00001234 next cycle, lo unchanged; start+mtlo same cycle -> mtlo dropped.
